// File: rtl/rv_multicycle_core.sv
// rv_multicycle_core: multi-cycle RV32I-subset processor.
// One FSM-sequenced datapath, one shared ALU, one unified memory.

module rv_mem #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);
    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [31:0]   RAM [0:MEM_WORDS-1];
    logic [AW-1:0] idx;
    logic          unused_addr;

    // word index wraps modulo the (power-of-two) depth
    assign idx         = addr_i[AW+1:2];
    assign rdata_o     = RAM[idx];
    assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};

    // word write on the rising edge
    always_ff @(posedge clk) begin
        if (we_i) RAM[idx] <= wdata_i;
    end
endmodule

module rv_multicycle_core #(
    parameter int          MEM_WORDS = 256,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input logic clk,
    input logic rst
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB,
        S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_BRANCH, S_JAL, S_JALR, S_LUI
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    state_t      state_q, state_d;
    logic [31:0] pc, original_pc, pc_plus_4, instruction;
    logic [31:0] a_q, b_q, alu_out_q, mdr_q;
    logic [31:0] rf [0:31];

    logic [31:0] pc_d, pc_for_alu, imm_extended;
    logic [31:0] alu_src_a, alu_src_b, alu_result;
    logic [31:0] rf_write_data, mem_addr, mem_rdata;
    logic        sel_original_pc, alu_func, taken;
    logic        we_pc, we_rf, we_mem, we_pc_plus_4, we_original_pc;
    logic        we_ir, we_ab, we_alu_out, we_mdr;

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;
    logic       alt;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];

    // bit 30 selects SUB only for R-type, SRA/SRAI for both
    assign alt = instruction[30]
               & ((state_q == S_EXEC_R) | (funct3 == 3'b101));

    assign pc_for_alu = sel_original_pc ? original_pc : pc;
    assign mem_addr   = (state_q == S_FETCH) ? pc : alu_out_q;
    assign taken      = (funct3[2:1] == 2'b00)
                      & ((a_q == b_q) ^ funct3[0]);

    rv_mem #(.MEM_WORDS(MEM_WORDS)) MEM (
        .clk     (clk),
        .we_i    (we_mem),
        .addr_i  (mem_addr),
        .wdata_i (b_q),
        .rdata_o (mem_rdata)
    );

    // immediate selection by instruction format
    always_comb begin
        imm_extended = {{20{instruction[31]}}, instruction[31:20]};
        case (opcode)
            OP_SW:  imm_extended = {{20{instruction[31]}},
                                    instruction[31:25], instruction[11:7]};
            OP_BR:  imm_extended = {{19{instruction[31]}}, instruction[31],
                                    instruction[7], instruction[30:25],
                                    instruction[11:8], 1'b0};
            OP_JAL: imm_extended = {{11{instruction[31]}}, instruction[31],
                                    instruction[19:12], instruction[20],
                                    instruction[30:21], 1'b0};
            OP_LUI: imm_extended = {instruction[31:12], 12'b0};
            default: ;
        endcase
    end

    // shared ALU: funct3-driven in EXEC states, add otherwise
    always_comb begin
        alu_result = alu_src_a + alu_src_b;
        if (alu_func) begin
            case (funct3)
                3'b000: alu_result = alt ? alu_src_a - alu_src_b
                                         : alu_src_a + alu_src_b;
                3'b001: alu_result = alu_src_a << alu_src_b[4:0];
                3'b010: alu_result = {31'b0,
                            $signed(alu_src_a) < $signed(alu_src_b)};
                3'b011: alu_result = {31'b0, alu_src_a < alu_src_b};
                3'b100: alu_result = alu_src_a ^ alu_src_b;
                3'b101: alu_result = alt
                            ? 32'($signed(alu_src_a) >>> alu_src_b[4:0])
                            : alu_src_a >> alu_src_b[4:0];
                3'b110: alu_result = alu_src_a | alu_src_b;
                default: alu_result = alu_src_a & alu_src_b;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_FETCH;
        else      state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:          state_d = S_EXEC_R;
                    OP_I:          state_d = S_EXEC_I;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BR:         state_d = S_BRANCH;
                    OP_JAL:        state_d = S_JAL;
                    OP_JALR:       state_d = S_JALR;
                    OP_LUI:        state_d = S_LUI;
                    default:       state_d = S_FETCH;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
            S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WRITE
                                                    : S_MEM_READ;
            S_MEM_READ: state_d = S_MEM_WB;
            default:    state_d = S_FETCH;
        endcase
    end

    // FSM outputs: datapath muxes and write enables
    always_comb begin
        sel_original_pc = 1'b0;
        alu_func        = 1'b0;
        alu_src_a       = pc_for_alu;
        alu_src_b       = imm_extended;
        rf_write_data   = alu_out_q;
        pc_d            = alu_result;
        we_pc           = 1'b0;
        we_rf           = 1'b0;
        we_mem          = 1'b0;
        we_pc_plus_4    = 1'b0;
        we_original_pc  = 1'b0;
        we_ir           = 1'b0;
        we_ab           = 1'b0;
        we_alu_out      = 1'b0;
        we_mdr          = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                alu_src_b      = 32'd4;
                we_pc          = 1'b1;
                we_original_pc = 1'b1;
                we_pc_plus_4   = 1'b1;
                we_ir          = 1'b1;
            end
            S_DECODE: we_ab = 1'b1;
            S_EXEC_R: begin
                alu_src_a  = a_q;
                alu_src_b  = b_q;
                alu_func   = 1'b1;
                we_alu_out = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a  = a_q;
                alu_func   = 1'b1;
                we_alu_out = 1'b1;
            end
            S_ALU_WB: we_rf = 1'b1;
            S_MEM_ADDR: begin
                alu_src_a  = a_q;
                we_alu_out = 1'b1;
            end
            S_MEM_READ: we_mdr = 1'b1;
            S_MEM_WB: begin
                rf_write_data = mdr_q;
                we_rf         = 1'b1;
            end
            S_MEM_WRITE: we_mem = 1'b1;
            S_BRANCH: begin
                sel_original_pc = 1'b1;
                alu_src_a       = original_pc;
                we_pc           = taken;
            end
            S_JAL: begin
                sel_original_pc = 1'b1;
                alu_src_a       = original_pc;
                rf_write_data   = pc_plus_4;
                we_rf           = 1'b1;
                we_pc           = 1'b1;
            end
            S_JALR: begin
                alu_src_a     = a_q;
                pc_d          = {alu_result[31:1], 1'b0};
                rf_write_data = pc_plus_4;
                we_rf         = 1'b1;
                we_pc         = 1'b1;
            end
            S_LUI: begin
                rf_write_data = imm_extended;
                we_rf         = 1'b1;
            end
            default: ;
        endcase
        if (!rst) begin
            we_pc          = 1'b0;
            we_rf          = 1'b0;
            we_mem         = 1'b0;
            we_pc_plus_4   = 1'b0;
            we_original_pc = 1'b0;
        end
    end

    // architectural and internal datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= RESET_PC;
            original_pc <= '0;
            pc_plus_4   <= '0;
            instruction <= '0;
            a_q         <= '0;
            b_q         <= '0;
            alu_out_q   <= '0;
            mdr_q       <= '0;
        end else begin
            if (we_pc)          pc          <= pc_d;
            if (we_original_pc) original_pc <= pc;
            if (we_pc_plus_4)   pc_plus_4   <= alu_result;
            if (we_ir)          instruction <= mem_rdata;
            if (we_ab) begin
                a_q <= rf[rs1];
                b_q <= rf[rs2];
            end
            if (we_alu_out)     alu_out_q   <= alu_result;
            if (we_mdr)         mdr_q       <= mem_rdata;
        end
    end

    // register file: x0 is never written so it always reads zero
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (we_rf && (rd != 5'd0)) begin
            rf[rd] <= rf_write_data;
        end
    end
endmodule

// File: tb/tb_rv_multicycle_core.sv
// tb_rv_multicycle_core: directed vectors for rv_multicycle_core.
// Table of single instructions plus hand sequences for memory, branches, reset.

module tb_rv_multicycle_core;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   wr_cnt = 0;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          cyc;
        int          wr;
    } vec_t;

    vec_t vq[$];

    rv_multicycle_core #(.MEM_WORDS(256), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (dut.we_rf) wr_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] enc_i(input logic [11:0] imm,
        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'h13};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7,
        input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm,
        input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm,
        input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm,
        input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [11:0] imm,
        input logic [4:0] rs1, input logic [4:0] rd);
        return {imm, rs1, 3'b000, rd, 7'h67};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm,
        input logic [4:0] rd);
        return {imm, rd, 7'h37};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rst_on;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic rst_off;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic clr_ram;
        for (int i = 0; i < 256; i++) dut.MEM.RAM[i] = 32'h0;
    endtask

    task automatic add(input logic [31:0] ins, input logic [4:0] rd,
                       input logic [31:0] exp, input int cyc, input int wr);
        vq.push_back('{ins, rd, exp, cyc, wr});
    endtask

    initial begin
        int base;

        add(enc_i(12'd5, 5'd0, 3'd0, 5'd1),          5'd1,  32'h5,        4, 1);
        add(enc_i(12'd3, 5'd1, 3'd0, 5'd2),          5'd2,  32'h8,        4, 1);
        add(enc_i(12'hFFD, 5'd0, 3'd0, 5'd5),        5'd5,  32'hFFFFFFFD, 4, 1);
        add(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd6),    5'd6,  32'hFFFFFFFD, 4, 1);
        add(enc_r(7'h00, 5'd1, 5'd5, 3'd2, 5'd7),    5'd7,  32'h1,        4, 1);
        add(enc_i(12'hFFF, 5'd5, 3'd2, 5'd8),        5'd8,  32'h1,        4, 1);
        add(enc_r(7'h20, 5'd1, 5'd5, 3'd5, 5'd9),    5'd9,  32'hFFFFFFFF, 4, 1);
        add(enc_r(7'h00, 5'd1, 5'd5, 3'd5, 5'd10),   5'd10, 32'h07FFFFFF, 4, 1);
        add(enc_r(7'h00, 5'd1, 5'd2, 3'd1, 5'd11),   5'd11, 32'h100,      4, 1);
        add(enc_i(12'h0F0, 5'd2, 3'd4, 5'd12),       5'd12, 32'hF8,       4, 1);
        add(enc_r(7'h00, 5'd2, 5'd5, 3'd7, 5'd13),   5'd13, 32'h8,        4, 1);
        add(enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd14),   5'd14, 32'hD,        4, 1);
        add(enc_r(7'h00, 5'd5, 5'd1, 3'd4, 5'd15),   5'd15, 32'hFFFFFFF8, 4, 1);
        add(enc_i(12'h01F, 5'd1, 3'd1, 5'd16),       5'd16, 32'h80000000, 4, 1);
        add(enc_i(12'h404, 5'd16, 3'd5, 5'd17),      5'd17, 32'hF8000000, 4, 1);
        add(enc_i(12'h004, 5'd16, 3'd5, 5'd18),      5'd18, 32'h08000000, 4, 1);
        add(enc_i(12'hFF0, 5'd5, 3'd7, 5'd19),       5'd19, 32'hFFFFFFF0, 4, 1);
        add(enc_i(12'h123, 5'd0, 3'd6, 5'd20),       5'd20, 32'h123,      4, 1);
        add(enc_r(7'h00, 5'd1, 5'd5, 3'd0, 5'd21),   5'd21, 32'h2,        4, 1);
        add(enc_u(20'hABCDE, 5'd22),                 5'd22, 32'hABCDE000, 3, 1);
        add(enc_i(12'd7, 5'd0, 3'd0, 5'd0),          5'd0,  32'h0,        4, 1);
        add(32'h0000000B,                            5'd1,  32'h5,        2, 0);
        add(enc_i(12'h400, 5'd1, 3'd0, 5'd23),       5'd23, 32'h405,      4, 1);
        add(enc_i(12'd6, 5'd1, 3'd2, 5'd24),         5'd24, 32'h1,        4, 1);

        // reset state and table program
        rst_on;
        clr_ram;
        foreach (vq[i]) dut.MEM.RAM[i] = vq[i].instr;
        chk("reset_pc", dut.pc, 32'h0);
        chk("reset_ir", dut.instruction, 32'h0);
        chk("reset_we_pc", {31'b0, dut.we_pc}, 32'h0);
        chk("reset_we_rf", {31'b0, dut.we_rf}, 32'h0);
        rst_off;
        for (int i = 0; i < vq.size(); i++) begin
            base = wr_cnt;
            step(vq[i].cyc);
            chk($sformatf("vec%0d_rd", i), dut.rf[vq[i].rd], vq[i].exp);
            chk($sformatf("vec%0d_pc", i), dut.pc, 32'(4 * (i + 1)));
            chk($sformatf("vec%0d_wr", i), 32'(wr_cnt - base),
                32'(vq[i].wr));
        end

        // lw of its own encoding: 5 cycles
        rst_on;
        clr_ram;
        dut.MEM.RAM[0] = 32'h00002083;
        chk("lw0_rf_reset", dut.rf[1], 32'h0);
        rst_off;
        step(4);
        chk("lw0_early", dut.rf[1], 32'h0);
        step(1);
        chk("lw0_x1", dut.rf[1], 32'h00002083);
        chk("lw0_pc", dut.pc, 32'h4);

        // sw then lw through memory
        rst_on;
        clr_ram;
        dut.MEM.RAM[0] = enc_i(12'd8, 5'd0, 3'd0, 5'd2);
        dut.MEM.RAM[1] = enc_s(12'd16, 5'd2, 5'd0);
        dut.MEM.RAM[2] = 32'h01002183;
        rst_off;
        step(4);
        chk("swlw_x2", dut.rf[2], 32'h8);
        step(4);
        chk("sw_ram4", dut.MEM.RAM[4], 32'h8);
        chk("sw_pc", dut.pc, 32'h8);
        step(4);
        chk("lw_x3_early", dut.rf[3], 32'h0);
        step(1);
        chk("lw_x3", dut.rf[3], 32'h8);
        chk("lw_pc", dut.pc, 32'hC);

        // branches and jumps
        rst_on;
        clr_ram;
        dut.MEM.RAM[0] = enc_i(12'd0, 5'd0, 3'd0, 5'd0);
        dut.MEM.RAM[1] = enc_i(12'd0, 5'd0, 3'd0, 5'd0);
        dut.MEM.RAM[2] = enc_b(13'd8, 5'd0, 5'd0, 3'd0);
        dut.MEM.RAM[4] = enc_b(13'd8, 5'd0, 5'd0, 3'd1);
        dut.MEM.RAM[5] = enc_j(21'd12, 5'd1);
        dut.MEM.RAM[7] = enc_b(13'd8, 5'd0, 5'd1, 3'd1);
        dut.MEM.RAM[8] = enc_jalr(12'd5, 5'd1, 5'd1);
        rst_off;
        step(8);
        chk("br_pre_pc", dut.pc, 32'h8);
        step(2);
        chk("beq_orig_pc", dut.original_pc, 32'h8);
        chk("beq_sel", {31'b0, dut.sel_original_pc}, 32'h1);
        chk("beq_alu", dut.alu_result, 32'h10);
        step(1);
        chk("beq_pc", dut.pc, 32'h10);
        step(3);
        chk("bne_nt_pc", dut.pc, 32'h14);
        step(3);
        chk("jal_x1", dut.rf[1], 32'h18);
        chk("jal_pc", dut.pc, 32'h20);
        step(3);
        chk("jalr_pc", dut.pc, 32'h1C);
        chk("jalr_x1", dut.rf[1], 32'h24);
        step(3);
        chk("bne_t_pc", dut.pc, 32'h24);

        // reset held across an ALU_WB cycle
        rst_on;
        clr_ram;
        dut.MEM.RAM[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd1);
        dut.MEM.RAM[1] = enc_i(12'd9, 5'd0, 3'd0, 5'd4);
        rst_off;
        step(4);
        chk("mr_x1", dut.rf[1], 32'h5);
        step(3);
        chk("mr_in_wb", {31'b0, dut.we_rf}, 32'h1);
        rst = 1'b0;
        #1;
        chk("mr_we_gated", {31'b0, dut.we_rf}, 32'h0);
        step(1);
        chk("mr_x4", dut.rf[4], 32'h0);
        chk("mr_pc", dut.pc, 32'h0);
        rst = 1'b1;
        step(4);
        chk("mr_re_ir", dut.instruction, enc_i(12'd5, 5'd0, 3'd0, 5'd1));
        chk("mr_re_x1", dut.rf[1], 32'h5);
        chk("mr_re_pc", dut.pc, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
